cpu7_tlb_dmw: RTL and testbench

Direct-mapped-window address translation unit for cpu7. It replaces the current pass-through registers that fake `itlb_*` and `dtlb_*` responses. It serves the icache translation port (`inst_tlb_*`) and the dcache translation port (`data_tlb_*`), and snoops the core's CSR write bus (`csr_wen/csr_waddr/csr_wdata`) to keep private copies of CRMD, DMW0 and DMW1. It sits between the pipeline CSR write-back and the two caches, with no page-table TLB behind it.

---
 rtl/cpu7_tlb_dmw_pkg.sv | 43 ++++
 rtl/cpu7_tlb_dmw_if.sv | 40 ++++
 rtl/cpu7_tlb_dmw_port.sv | 58 +++++
 rtl/cpu7_tlb_dmw.sv | 37 +++
 tb/tb_cpu7_tlb_dmw.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/cpu7_tlb_dmw_pkg.sv
// cpu7_tlb_dmw_pkg: CSR addresses, field positions, exception codes and shared types for the DMW translator
package cpu7_tlb_dmw_pkg;
  localparam logic [13:0] CSR_CRMD = 14'h000;
  localparam logic [13:0] CSR_DMW0 = 14'h180;
  localparam logic [13:0] CSR_DMW1 = 14'h181;
  localparam int CRMD_PLV  = 0;
  localparam int CRMD_DA   = 3;
  localparam int CRMD_PG   = 4;
  localparam int CRMD_DATF = 5;
  localparam int CRMD_DATM = 7;
  localparam int DMW_PLV0  = 0;
  localparam int DMW_PLV3  = 3;
  localparam int DMW_MAT   = 4;
  localparam int DMW_PSEG  = 25;
  localparam int DMW_VSEG  = 29;
  localparam logic [5:0] EXC_TLBR = 6'h3F;
  localparam logic [5:0] EXC_ADEF = 6'h08;
  typedef enum logic {ST_IDLE, ST_RESP} resp_st_e;
  typedef struct packed {
    logic [1:0] datm;
    logic [1:0] datf;
    logic       pg;
    logic       da;
    logic [1:0] plv;
  } crmd_t;
  typedef struct packed {
    logic [2:0] vseg;
    logic [2:0] pseg;
    logic [1:0] mat;
    logic       plv3;
    logic       plv0;
  } dmw_t;
  localparam crmd_t CRMD_RST = '{da: 1'b1, default: '0};
  function automatic crmd_t crmd_decode(logic [31:0] d);
    return '{plv: d[CRMD_PLV+:2], da: d[CRMD_DA], pg: d[CRMD_PG], datf: d[CRMD_DATF+:2], datm: d[CRMD_DATM+:2]};
  endfunction
  function automatic dmw_t dmw_decode(logic [31:0] d);
    return '{plv0: d[DMW_PLV0], plv3: d[DMW_PLV3], mat: d[DMW_MAT+:2], pseg: d[DMW_PSEG+:3], vseg: d[DMW_VSEG+:3]};
  endfunction
  function automatic logic dmw_match(dmw_t d, logic [2:0] vs, logic [1:0] plv);
    return d.vseg == vs && (plv == 2'd0 ? d.plv0 : plv == 2'd3 && d.plv3);
  endfunction
endpackage

// File: rtl/cpu7_tlb_dmw_if.sv
// cpu7_tlb_dmw_if: CSR snoop bus plus icache and dcache translation ports
interface cpu7_tlb_dmw_if #(parameter int GRLEN = 32, parameter int PABITS = 32, parameter int CSR_BIT = 14);
  logic               csr_wen;
  logic [CSR_BIT-1:0] csr_waddr;
  logic [GRLEN-1:0]   csr_wdata;
  logic               inst_tlb_req;
  logic [GRLEN-1:0]   inst_tlb_vaddr;
  logic               inst_tlb_cacop;
  logic               itlb_cache_recv;
  logic               itlb_finish;
  logic               itlb_hit;
  logic               itlb_uncache;
  logic [PABITS-1:0]  itlb_paddr;
  logic [5:0]         itlb_exccode;
  logic               data_tlb_req;
  logic               data_tlb_wr;
  logic [GRLEN-1:0]   data_tlb_vaddr;
  logic               dtlb_no_trans;
  logic               dtlb_p_pgcl;
  logic               dtlb_cache_recv;
  logic               dtlb_finish;
  logic               dtlb_hit;
  logic               dtlb_uncache;
  logic [PABITS-1:0]  dtlb_paddr;
  logic [5:0]         dtlb_exccode;
  modport master(
    output csr_wen, csr_waddr, csr_wdata,
    output inst_tlb_req, inst_tlb_vaddr, inst_tlb_cacop, itlb_cache_recv,
    input  itlb_finish, itlb_hit, itlb_uncache, itlb_paddr, itlb_exccode,
    output data_tlb_req, data_tlb_wr, data_tlb_vaddr, dtlb_no_trans, dtlb_p_pgcl, dtlb_cache_recv,
    input  dtlb_finish, dtlb_hit, dtlb_uncache, dtlb_paddr, dtlb_exccode
  );
  modport slave(
    input  csr_wen, csr_waddr, csr_wdata,
    input  inst_tlb_req, inst_tlb_vaddr, inst_tlb_cacop, itlb_cache_recv,
    output itlb_finish, itlb_hit, itlb_uncache, itlb_paddr, itlb_exccode,
    input  data_tlb_req, data_tlb_wr, data_tlb_vaddr, dtlb_no_trans, dtlb_p_pgcl, dtlb_cache_recv,
    output dtlb_finish, dtlb_hit, dtlb_uncache, dtlb_paddr, dtlb_exccode
  );
endinterface

// File: rtl/cpu7_tlb_dmw_port.sv
// cpu7_tlb_dmw_port: one translation port, window lookup feeding a registered IDLE/RESP response
module cpu7_tlb_dmw_port import cpu7_tlb_dmw_pkg::*; #(parameter int GRLEN = 32, parameter int PABITS = 32) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic              i_recv,
  input  logic [GRLEN-1:0]  i_vaddr,
  input  logic              i_direct,
  input  logic              i_align,
  input  logic [1:0]        i_plv,
  input  logic [1:0]        i_mat,
  input  dmw_t              i_dmw0,
  input  dmw_t              i_dmw1,
  output logic              o_finish,
  output logic              o_hit,
  output logic              o_uncache,
  output logic [PABITS-1:0] o_paddr,
  output logic [5:0]        o_exccode
);
  resp_st_e          r_st;
  logic              w_m0, w_m1, w_win, w_mis, w_hit, w_uc, w_cap;
  dmw_t              w_dmw;
  logic [31:0]       w_wpa;
  logic [PABITS-1:0] w_pa;
  logic [5:0]        w_exc;
  always_comb begin
    w_m0  = dmw_match(i_dmw0, i_vaddr[31:29], i_plv);
    w_m1  = dmw_match(i_dmw1, i_vaddr[31:29], i_plv);
    w_dmw = w_m0 ? i_dmw0 : i_dmw1;
    w_wpa = {w_dmw.pseg, i_vaddr[28:0]};
    w_mis = i_align && i_vaddr[1:0] != 2'b00;
    w_win = !i_direct && (w_m0 || w_m1);
    w_hit = !w_mis && (i_direct || w_win);
    w_uc  = w_mis ? 1'b0 : i_direct ? i_mat == 2'b00 : w_win && w_dmw.mat == 2'b00;
    w_pa  = !w_mis && w_win ? PABITS'(w_wpa) : PABITS'(i_vaddr);
    w_exc = w_mis ? EXC_ADEF : w_hit ? 6'h00 : EXC_TLBR;
    w_cap = i_req && (r_st == ST_IDLE || i_recv);
  end
  // a held response (RESP, no recv) ignores new requests and keeps its old result
  always_ff @(posedge clk) begin
    if (reset) begin
      r_st      <= ST_IDLE;
      o_hit     <= 1'b0;
      o_uncache <= 1'b0;
      o_paddr   <= '0;
      o_exccode <= '0;
    end else if (w_cap) begin
      r_st      <= ST_RESP;
      o_hit     <= w_hit;
      o_uncache <= w_uc;
      o_paddr   <= w_pa;
      o_exccode <= w_exc;
    end else if (r_st == ST_RESP && i_recv) begin
      r_st <= ST_IDLE;
    end
  end
  assign o_finish = r_st == ST_RESP;
endmodule

// File: rtl/cpu7_tlb_dmw.sv
// cpu7_tlb_dmw: direct-mapped-window translator for the icache and dcache, with snooped CRMD/DMW0/DMW1 copies
module cpu7_tlb_dmw import cpu7_tlb_dmw_pkg::*; #(parameter int GRLEN = 32, parameter int PABITS = 32, parameter int CSR_BIT = 14) (
  input logic clk,
  input logic reset,
  cpu7_tlb_dmw_if.slave bus
);
  crmd_t r_crmd;
  dmw_t  r_dmw0, r_dmw1;
  logic  w_unused;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_crmd <= CRMD_RST;
      r_dmw0 <= '0;
      r_dmw1 <= '0;
    end else if (bus.csr_wen) begin
      if (bus.csr_waddr == CSR_BIT'(CSR_CRMD)) r_crmd <= crmd_decode(bus.csr_wdata[31:0]);
      if (bus.csr_waddr == CSR_BIT'(CSR_DMW0)) r_dmw0 <= dmw_decode(bus.csr_wdata[31:0]);
      if (bus.csr_waddr == CSR_BIT'(CSR_DMW1)) r_dmw1 <= dmw_decode(bus.csr_wdata[31:0]);
    end
  end
  // DA alone selects direct mode, so PG is kept only as a shadow copy
  assign w_unused = ^{r_crmd.pg, bus.csr_wdata, bus.data_tlb_wr, bus.dtlb_p_pgcl};
  cpu7_tlb_dmw_port #(.GRLEN(GRLEN), .PABITS(PABITS)) u_inst (
    .clk(clk), .reset(reset), .i_req(bus.inst_tlb_req), .i_recv(bus.itlb_cache_recv),
    .i_vaddr(bus.inst_tlb_vaddr), .i_direct(r_crmd.da), .i_align(!bus.inst_tlb_cacop),
    .i_plv(r_crmd.plv), .i_mat(r_crmd.datf), .i_dmw0(r_dmw0), .i_dmw1(r_dmw1),
    .o_finish(bus.itlb_finish), .o_hit(bus.itlb_hit), .o_uncache(bus.itlb_uncache),
    .o_paddr(bus.itlb_paddr), .o_exccode(bus.itlb_exccode)
  );
  cpu7_tlb_dmw_port #(.GRLEN(GRLEN), .PABITS(PABITS)) u_data (
    .clk(clk), .reset(reset), .i_req(bus.data_tlb_req), .i_recv(bus.dtlb_cache_recv),
    .i_vaddr(bus.data_tlb_vaddr), .i_direct(r_crmd.da || bus.dtlb_no_trans), .i_align(1'b0),
    .i_plv(r_crmd.plv), .i_mat(r_crmd.datm), .i_dmw0(r_dmw0), .i_dmw1(r_dmw1),
    .o_finish(bus.dtlb_finish), .o_hit(bus.dtlb_hit), .o_uncache(bus.dtlb_uncache),
    .o_paddr(bus.dtlb_paddr), .o_exccode(bus.dtlb_exccode)
  );
endmodule

// File: tb/tb_cpu7_tlb_dmw.sv
// tb_cpu7_tlb_dmw: directed vectors with per-port expected-response queues checked by negedge monitors
module tb_cpu7_tlb_dmw;
  typedef struct packed {
    logic [31:0] pa;
    logic        hit;
    logic        uc;
    logic [5:0]  exc;
  } rsp_t;
  logic clk = 0;
  logic reset = 1;
  int   checks = 0;
  int   errors = 0;
  rsp_t iq[$];
  rsp_t dq[$];
  cpu7_tlb_dmw_if bus();
  cpu7_tlb_dmw dut(.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic cmp(input string p, input rsp_t e, input logic [31:0] pa, input logic hit, input logic uc, input logic [5:0] exc);
    chk({p, "_paddr"}, pa, e.pa);
    chk({p, "_hit"}, {31'b0, hit}, {31'b0, e.hit});
    chk({p, "_uncache"}, {31'b0, uc}, {31'b0, e.uc});
    chk({p, "_exccode"}, {26'b0, exc}, {26'b0, e.exc});
  endtask
  always @(negedge clk) begin
    if (!reset && bus.itlb_finish) begin
      if (iq.size() == 0) chk("itlb_unexpected_finish", 1, 0);
      else begin
        cmp("itlb", iq[0], bus.itlb_paddr, bus.itlb_hit, bus.itlb_uncache, bus.itlb_exccode);
        if (bus.itlb_cache_recv) void'(iq.pop_front());
      end
    end
  end
  always @(negedge clk) begin
    if (!reset && bus.dtlb_finish) begin
      if (dq.size() == 0) chk("dtlb_unexpected_finish", 1, 0);
      else begin
        cmp("dtlb", dq[0], bus.dtlb_paddr, bus.dtlb_hit, bus.dtlb_uncache, bus.dtlb_exccode);
        if (bus.dtlb_cache_recv) void'(dq.pop_front());
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic ireq(input logic [31:0] va, input logic cacop, input logic [31:0] pa, input logic hit, input logic uc, input logic [5:0] exc);
    bus.inst_tlb_req = 1;
    bus.inst_tlb_vaddr = va;
    bus.inst_tlb_cacop = cacop;
    iq.push_back('{pa: pa, hit: hit, uc: uc, exc: exc});
    step();
    bus.inst_tlb_req = 0;
  endtask
  task automatic dreq(input logic [31:0] va, input logic nt, input logic [31:0] pa, input logic hit, input logic uc, input logic [5:0] exc);
    bus.data_tlb_req = 1;
    bus.data_tlb_vaddr = va;
    bus.dtlb_no_trans = nt;
    dq.push_back('{pa: pa, hit: hit, uc: uc, exc: exc});
    step();
    bus.data_tlb_req = 0;
    bus.dtlb_no_trans = 0;
  endtask
  task automatic csr(input logic [13:0] a, input logic [31:0] d);
    bus.csr_wen = 1;
    bus.csr_waddr = a;
    bus.csr_wdata = d;
    step();
    bus.csr_wen = 0;
  endtask
  task automatic drain();
    repeat (3) step();
    chk("itlb_queue_drained", iq.size(), 0);
    chk("dtlb_queue_drained", dq.size(), 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    bus.csr_wen = 0; bus.csr_waddr = 0; bus.csr_wdata = 0;
    bus.inst_tlb_req = 0; bus.inst_tlb_vaddr = 0; bus.inst_tlb_cacop = 0; bus.itlb_cache_recv = 1;
    bus.data_tlb_req = 0; bus.data_tlb_wr = 0; bus.data_tlb_vaddr = 0;
    bus.dtlb_no_trans = 0; bus.dtlb_p_pgcl = 0; bus.dtlb_cache_recv = 1;
    repeat (3) step();
    @(negedge clk);
    chk("rst_itlb_outs", {bus.itlb_finish, bus.itlb_hit, bus.itlb_uncache, bus.itlb_exccode, 23'b0}, 0);
    chk("rst_itlb_paddr", bus.itlb_paddr, 0);
    chk("rst_dtlb_outs", {bus.dtlb_finish, bus.dtlb_hit, bus.dtlb_uncache, bus.dtlb_exccode, 23'b0}, 0);
    chk("rst_dtlb_paddr", bus.dtlb_paddr, 0);
    step();
    reset = 0;
    ireq(32'h1C000000, 0, 32'h1C000000, 1, 1, 6'h00);
    dreq(32'h1C000040, 0, 32'h1C000040, 1, 1, 6'h00);
    ireq(32'h1C000004, 0, 32'h1C000004, 1, 1, 6'h00);
    drain();
    csr(14'h180, 32'h80000011);
    csr(14'h123, 32'hFFFFFFFF);
    csr(14'h000, 32'h00000010);
    dreq(32'h80001234, 0, 32'h00001234, 1, 0, 6'h00);
    ireq(32'h80000100, 0, 32'h00000100, 1, 0, 6'h00);
    dreq(32'h40000000, 0, 32'h40000000, 0, 0, 6'h3F);
    ireq(32'h1C000002, 0, 32'h1C000002, 0, 0, 6'h08);
    ireq(32'h1C000002, 1, 32'h1C000002, 0, 0, 6'h3F);
    ireq(32'h80000102, 0, 32'h80000102, 0, 0, 6'h08);
    dreq(32'h40000000, 1, 32'h40000000, 1, 1, 6'h00);
    drain();
    csr(14'h181, 32'h82000009);
    dreq(32'h80000040, 0, 32'h00000040, 1, 0, 6'h00);
    csr(14'h000, 32'h00000013);
    dreq(32'h80000040, 0, 32'h20000040, 1, 1, 6'h00);
    csr(14'h000, 32'h00000011);
    dreq(32'h80000040, 0, 32'h80000040, 0, 0, 6'h3F);
    csr(14'h000, 32'h00000010);
    drain();
    bus.dtlb_cache_recv = 0;
    dreq(32'h80000abc, 0, 32'h00000abc, 1, 0, 6'h00);
    repeat (2) step();
    bus.dtlb_cache_recv = 1;
    step();
    @(negedge clk);
    chk("held_finish_drops", {31'b0, bus.dtlb_finish}, 0);
    step();
    bus.csr_wen = 1;
    bus.csr_waddr = 14'h180;
    bus.csr_wdata = 32'h84000011;
    dreq(32'h80000010, 0, 32'h00000010, 1, 0, 6'h00);
    bus.csr_wen = 0;
    dreq(32'h80000010, 0, 32'h40000010, 1, 0, 6'h00);
    drain();
    bus.dtlb_cache_recv = 0;
    dreq(32'h80000020, 0, 32'h40000020, 1, 0, 6'h00);
    step();
    reset = 1;
    step();
    @(negedge clk);
    chk("rst_in_resp_finish", {31'b0, bus.dtlb_finish}, 0);
    chk("rst_in_resp_hit", {31'b0, bus.dtlb_hit}, 0);
    chk("rst_in_resp_paddr", bus.dtlb_paddr, 0);
    dq.delete();
    step();
    reset = 0;
    bus.dtlb_cache_recv = 1;
    dreq(32'h80000020, 0, 32'h80000020, 1, 1, 6'h00);
    ireq(32'h80000100, 0, 32'h80000100, 1, 1, 6'h00);
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
